desync: RTL and testbench
=========================

// Module: desync
// PURPOSE
//  Clocked-to-async link transmitter that sits directly upstream of the dual-rail receiver (sync).
//  Accepts words on a valid/ready interface and buffers them in a small FIFO.
//  Drives each word onto a dual-rail link in TP (two-phase) or FP (four-phase, RZ) encoding.
//  Paces tokens using the receiver's completion acknowledge.
// PARAMETERS
//  ENC      "TP"  link encoding: "TP" two-phase transition, "FP" four-phase return-to-zero
//  WIDTH    1     data bits per token
//  DEPTH    4     FIFO entries; power of 2, >=2
//  TIMEOUT  1024  ack watchdog limit in clk cycles (used only with DESYNC_TIMEOUT_EN)
//  RAIL_NUM 2     localparam, rails per bit
// PORTS
//  clk       in   1                 single clock
//  rst       in   1                 synchronous, active-high reset
//  in_valid  in   1                 upstream word valid
//  in_ready  out  1                 FIFO can accept; = !full
//  in        in   WIDTH             upstream word
//  out       out  [WIDTH][RAIL_NUM] dual-rail link; [b][1]=one-rail, [b][0]=zero-rail
//  ack_i     in   1                 completion ack from receiver (async to clk)
//  err       out  1                 sticky ack-timeout flag; tied 0 without DESYNC_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: out=all 0, in_ready=0 during rst and 1 the cycle after, err=0, FIFO empty,
//    FSM=IDLE, phase=0, ack synchroniser flops=0. Receiver must be reset in the same window.
//  - Push: in_valid&&in_ready at edge N writes FIFO.
//    in_ready is registered from count before the edge, so no push is taken when full.
//  - Simultaneous push and pop is legal whenever the FIFO is neither full nor empty before the edge.
//  - ack_i passes through a 2-flop synchroniser -> ack_s. FSM uses only ack_s.
//  - FSM IDLE: FIFO non-empty -> pop head, register rails -> SEND.
//    Earliest out change is edge N+1 after push. Empty FIFO -> stay, out holds.
//  - SEND, FP mode:
//    * out[b] = {d[b], ~d[b]}, i.e. 01 = zero, 10 = one.
//    * Wait for ack_s==1, then drive out=all 0 (spacer) -> RTZ.
//  - RTZ (FP only): wait for ack_s==0 -> IDLE. A new token may launch on the next edge.
//  - SEND, TP mode:
//    * Toggle out[b][d[b]] once per bit (one-rail for 1, zero-rail for 0). Other rail holds.
//    * Expected ack = ~phase. When ack_s==~phase: phase<=~phase -> IDLE.
//  - Exactly one rail per bit changes per token. No rail glitches; all rail flops are registered.
//  - Minimum token period: FP 1+2+1+2+1 cycles, TP 1+2+1 cycles, plus receiver delay.
//  - ack_s toggling while in IDLE is a protocol violation. It is ignored; phase is not updated.
//  - Reset mid-token: the token is abandoned, the FIFO is flushed, and out returns to 0 on the reset edge.
// CONFIGURATION
//  DESYNC_TIMEOUT_EN defined:
//    * A 16-bit counter clears on entry to SEND/RTZ and increments while waiting.
//    * Reaching TIMEOUT sets err (sticky until rst). The FSM keeps waiting; no token is dropped.
//  Not defined: no counter, err tied 0, no timing effect.
// STRUCTURE
//  - async_pkg holds:
//    * enc string constants ENC_TP / ENC_FP, RAIL_0/RAIL_1 indices.
//    * state_t typedef {IDLE, SEND, RTZ}.
//  - Sub-module ack_sync: 2-flop synchroniser (clk, rst, d, q), reset value 0.
//  - FIFO is inline (circular buffer, ptr width $clog2(DEPTH)+1 for full/empty).
// TESTING
//  1 FP, WIDTH=4: push 4'hA, ack model raises ack 3ns after valid rails and drops after spacer
//    -> out=10_01_10_01, then all 0; receiver output = 4'hA.
//  2 TP, WIDTH=2: push 2'b01, 2'b01
//    -> first token toggles out[0][1] and out[1][0]; second toggles the same rails back.
//    -> phase returns to 0 after two acks.
//  3 DEPTH=4, ack held 0: push 6 words back-to-back
//    -> in_ready drops after 5 accepts (4 in FIFO + 1 in flight).
//    -> Releasing ack drains them in order.
//  4 Assert rst for 1 cycle while in SEND with 3 words queued
//    -> out=0 next edge, in_ready=0 during rst, no further tokens without new pushes.
//  5 DESYNC_TIMEOUT_EN, TIMEOUT=16: withhold ack
//    -> err=1 exactly 16 cycles after SEND entry. A late ack still completes the token; err stays 1.
//  6 Spurious ack_i toggle in IDLE (TP)
//    -> no out change, phase unchanged; next legit token completes normally.

Source files
------------

// File: rtl/async_pkg.sv
// Shared constants and types for the clocked-to-async link transmitter.
//   ENC_TP / ENC_FP : encoding selectors for the desync ENC parameter
//   RAIL_0 / RAIL_1 : rail indices within one dual-rail bit
//   state_t         : transmitter FSM states
package async_pkg;
  localparam int          RAIL_NUM = 2;
  localparam int          RAIL_0   = 0;  // zero-rail
  localparam int          RAIL_1   = 1;  // one-rail
  localparam logic [15:0] ENC_TP   = "TP";
  localparam logic [15:0] ENC_FP   = "FP";

  typedef enum logic [1:0] {IDLE, SEND, RTZ} state_t;
endpackage

// File: rtl/desync_ack_sync.sv
// Two-flop synchroniser for the receiver's completion acknowledge.
//   clk : sampling clock
//   rst : synchronous active-high reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles of latency
module ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/desync.sv
// Clocked-to-async dual-rail link transmitter. Words arrive on valid/ready,
// are buffered in a small circular FIFO, and are launched one token at a time
// onto a dual-rail link, paced by the receiver's completion acknowledge.
//   clk      : single clock
//   rst      : synchronous active-high reset (abandons any token, flushes FIFO)
//   in_valid : upstream word valid
//   in_ready : registered !full; low while in reset
//   in       : upstream word
//   out      : dual-rail link, out[b][1] one-rail, out[b][0] zero-rail
//   ack_i    : receiver completion ack, asynchronous to clk
//   err      : sticky ack-timeout flag
// Optional feature macro: DESYNC_TIMEOUT_EN enables the ack watchdog driving
// err; without it err is tied 0.
module desync
  import async_pkg::*;
#(
  parameter logic [15:0] ENC     = ENC_TP,
  parameter int          WIDTH   = 1,
  parameter int          DEPTH   = 4,
  parameter int          TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]   out,
  input  logic                             ack_i,
  output logic                             err
);
  localparam int         PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam bit         IS_FP    = (ENC == ENC_FP);

  logic                           ack_s;
  state_t                         state_q, state_d;
  logic [WIDTH-1:0][RAIL_NUM-1:0] out_q, out_d;
  logic                           phase_q, phase_d;
  logic                           in_ready_q;
  logic [WIDTH-1:0]               mem_q [DEPTH];
  logic [PW:0]                    wptr_q, wptr_d, rptr_q, rptr_d;
  logic                           push, pop, empty;
  logic [WIDTH-1:0]               head;

  ack_sync u_ack_sync (.clk(clk), .rst(rst), .d(ack_i), .q(ack_s));

  // ---------------- FIFO ----------------
  assign push   = in_valid & in_ready_q;
  assign empty  = (wptr_q == rptr_q);
  assign head   = mem_q[rptr_q[PW-1:0]];
  assign wptr_d = wptr_q + {{PW{1'b0}}, push};
  assign rptr_d = rptr_q + {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      // Registered from the post-edge occupancy, so in_ready == !full.
      in_ready_q <= ((wptr_d - rptr_d) != FULL_CNT);
    end
  end

  assign in_ready = in_ready_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      phase_q <= phase_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!empty) state_d = SEND;
      SEND: begin
        if (IS_FP) begin
          if (ack_s) state_d = RTZ;
        end else if (ack_s == ~phase_q) begin
          state_d = IDLE;
        end
      end
      RTZ:  if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // ack_s activity in IDLE/RTZ never touches phase; only a completed TP
  // handshake in SEND advances it.
  always_comb begin
    out_d   = out_q;
    phase_d = phase_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          for (int b = 0; b < WIDTH; b++) begin
            if (IS_FP) out_d[b] = {head[b], ~head[b]};
            else       out_d[b][head[b]] = ~out_q[b][head[b]];
          end
        end
      end
      SEND: begin
        if (IS_FP) begin
          if (ack_s) out_d = '0;  // spacer
        end else if (ack_s == ~phase_q) begin
          phase_d = ~phase_q;
        end
      end
      default: ;
    endcase
  end

  assign out = out_q;

  // ---------------- ack watchdog ----------------
`ifdef DESYNC_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q != IDLE) begin
      if (tmo_q != '1) tmo_d = tmo_q + 16'd1;
      if (tmo_q == 16'(TIMEOUT - 1)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_desync.sv
module tb_desync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [3:0] din = '0;
  logic fp_rdy, tp_rdy, fp_err, tp_err;
  logic [3:0][1:0] fp_out;
  logic [1:0][1:0] tp_out;
  logic fp_ack = 1'b0;
  logic tp_ack = 1'b0;
  bit hold = 0;
  bit spur_req = 0;

  int vecs = 0;
  int errs = 0;

  logic [3:0] fp_q[$];
  logic [1:0] tp_q[$];

  always #5 clk = ~clk;

  desync #(.ENC("FP"), .WIDTH(4), .DEPTH(4), .TIMEOUT(16)) u_fp (
    .clk(clk), .rst(rst), .in_valid(vld), .in_ready(fp_rdy), .in(din),
    .out(fp_out), .ack_i(fp_ack), .err(fp_err));

  desync #(.ENC("TP"), .WIDTH(2), .DEPTH(4), .TIMEOUT(16)) u_tp (
    .clk(clk), .rst(rst), .in_valid(vld), .in_ready(tp_rdy), .in(din[1:0]),
    .out(tp_out), .ack_i(tp_ack), .err(tp_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    errs++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- FP receiver / monitor ----------------
  int         fp_st = 0;
  int         fp_dly = 0;
  logic [3:0] fp_w;
  bit         fp_bad, fp_full;

  always @(negedge clk) begin
    if (rst) begin
      fp_ack = 1'b0;
      fp_st  = 0;
    end else begin
      case (fp_st)
        0: begin
          fp_bad  = 0;
          fp_full = 1;
          for (int b = 0; b < 4; b++) begin
            if (fp_out[b] == 2'b11) fp_bad = 1;
            if (fp_out[b] == 2'b00) fp_full = 0;
            fp_w[b] = fp_out[b][1];
          end
          if (fp_bad) fail("fp_rail_pair", {24'd0, fp_out}, 32'd0);
          else if (fp_full) begin
            if (fp_q.size() == 0) fail("fp_extra_token", {28'd0, fp_w}, 32'd0);
            else chk("fp_token", {28'd0, fp_w}, {28'd0, fp_q.pop_front()});
            fp_dly = $urandom_range(0, 3);
            fp_st  = 1;
          end
        end
        1: if (!hold) begin
          if (fp_dly == 0) begin fp_ack = 1'b1; fp_st = 2; end
          else fp_dly--;
        end
        2: if (fp_out == '0) begin fp_dly = $urandom_range(0, 3); fp_st = 3; end
        default: begin
          if (fp_dly == 0) begin fp_ack = 1'b0; fp_st = 0; end
          else fp_dly--;
        end
      endcase
    end
  end

  // ---------------- TP receiver / monitor ----------------
  // tp_model holds the rail levels implied by every word handed to the link:
  // each word flips, per bit, the rail named by that bit's value.
  int              tp_st = 0;
  int              tp_dly = 0;
  logic [1:0][1:0] tp_model = '0;
  logic [1:0][1:0] tp_next;
  logic [1:0]      tp_e;

  always @(negedge clk) begin
    if (rst) begin
      tp_ack   = 1'b0;
      tp_st    = 0;
      tp_model = '0;
      spur_req = 0;
    end else begin
      case (tp_st)
        0: begin
          if (tp_out != tp_model) begin
            if (tp_q.size() == 0) begin
              fail("tp_extra_token", {28'd0, tp_out}, {28'd0, tp_model});
              tp_model = tp_out;
            end else begin
              tp_e    = tp_q.pop_front();
              tp_next = tp_model;
              for (int b = 0; b < 2; b++) tp_next[b][tp_e[b]] = ~tp_next[b][tp_e[b]];
              chk("tp_token_rails", {28'd0, tp_out}, {28'd0, tp_next});
              tp_model = tp_out;
              tp_dly   = $urandom_range(0, 3);
              tp_st    = 1;
            end
          end else if (spur_req) begin
            tp_ack   = ~tp_ack;
            spur_req = 0;
            tp_dly   = 6;
            tp_st    = 4;
          end
        end
        1: begin
          if (tp_out != tp_model) begin
            fail("tp_early_change", {28'd0, tp_out}, {28'd0, tp_model});
            tp_model = tp_out;
          end else if (!hold) begin
            if (tp_dly == 0) begin tp_ack = ~tp_ack; tp_st = 0; end
            else tp_dly--;
          end
        end
        4: begin
          if (tp_dly == 0) begin tp_ack = ~tp_ack; tp_dly = 4; tp_st = 5; end
          else tp_dly--;
        end
        default: begin
          if (tp_dly == 0) tp_st = 0;
          else tp_dly--;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [3:0] w, input int budget, output bit ok);
    ok = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (fp_rdy && tp_rdy) begin
        vld = 1'b1;
        din = w;
        fp_q.push_back(w);
        tp_q.push_back(w[1:0]);
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1 vld = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((fp_q.size() != 0 || tp_q.size() != 0 || fp_st != 0 || tp_st != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, (t >= 3000) ? 32'd1 : 32'd0, 32'd0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int acc;
    int t;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fp_ready", fp_rdy, 0);
    chk("rst_tp_ready", tp_rdy, 0);
    chk("rst_fp_out", fp_out, 0);
    chk("rst_tp_out", tp_out, 0);
    chk("rst_fp_err", fp_err, 0);
    chk("rst_tp_err", tp_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_fp_ready", fp_rdy, 1);
    chk("post_rst_tp_ready", tp_rdy, 1);

    // FP 4'hA encoding; TP low bits 2'b10
    hold = 1;
    push(4'hA, 4, ok);
    repeat (2) @(posedge clk);
    #1;
    chk("fp_rails_A", fp_out, 8'b10_01_10_01);
    chk("tp_rails_10", tp_out, 4'b10_01);
    hold = 0;
    drain("drain_A");
    chk("fp_spacer_idle", fp_out, 0);

    // TP 2'b01 twice: rails toggle out and back
    push(4'h1, 10, ok);
    push(4'h1, 10, ok);
    drain("drain_01");
    chk("tp_rails_return", tp_out, 4'b10_01);

    // Back-to-back fill with ack withheld
    hold = 1;
    acc  = 0;
    for (int i = 0; i < 6; i++) begin
      push(4'(i + 3), (i < 5) ? 2 : 6, ok);
      if (ok) acc++;
    end
    chk("accepts_before_full", acc, 5);
    chk("full_fp_ready", fp_rdy, 0);
    chk("full_tp_ready", tp_rdy, 0);
    hold = 0;
    drain("drain_full");

    // Reset mid-token with three words queued
    hold = 1;
    for (int i = 0; i < 4; i++) push(4'(4'hC + i), 4, ok);
    @(posedge clk);
    #1 rst = 1'b1;
    fp_q.delete();
    tp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_fp_out", fp_out, 0);
    chk("midrst_tp_out", tp_out, 0);
    chk("midrst_fp_ready", fp_rdy, 0);
    chk("midrst_tp_ready", tp_rdy, 0);
    rst  = 1'b0;
    hold = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("after_rst_fp_out", fp_out, 0);
    chk("after_rst_tp_out", tp_out, 0);
    chk("after_rst_fp_ready", fp_rdy, 1);
    chk("after_rst_err", {fp_err, tp_err}, 0);

`ifdef DESYNC_TIMEOUT_EN
    // Watchdog: err rises exactly 16 cycles after SEND entry (edge after push)
    hold = 1;
    push(4'h6, 4, ok);
    repeat (16) @(posedge clk);
    #1;
    chk("tmo_early_err", {fp_err, tp_err}, 2'b00);
    @(posedge clk);
    #1;
    chk("tmo_err", {fp_err, tp_err}, 2'b11);
    hold = 0;
    drain("drain_tmo");
    chk("tmo_err_sticky", {fp_err, tp_err}, 2'b11);
`endif

    // Spurious ack pulse while TP is idle
    spur_req = 1;
    t = 0;
    while ((spur_req || tp_st != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("spur_done", (t >= 100) ? 32'd1 : 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    chk("spur_tp_out", {28'd0, tp_out}, {28'd0, tp_model});
    push(4'h2, 10, ok);
    drain("drain_after_spur");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      push(4'($urandom), 200, ok);
      if (!ok) fail("rand_push_stall", 0, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain("drain_random");

`ifndef DESYNC_TIMEOUT_EN
    chk("err_tied_low", {fp_err, tp_err}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
